// File: rtl/rf_pkg.sv
// RF front-end switch sequencer: shared mode codes, pin patterns, pin indices and FSM encoding.
package rf_pkg;

  localparam int unsigned MODE_W = 3;
  localparam int unsigned PINS_W = 8;
  localparam int unsigned CNT_W  = 8;

  localparam logic [MODE_W-1:0] MODE_LOW_POWER = 3'd0;
  localparam logic [MODE_W-1:0] MODE_BYPASS    = 3'd1;
  localparam logic [MODE_W-1:0] MODE_RX_LPF    = 3'd2;
  localparam logic [MODE_W-1:0] MODE_RX_HPF    = 3'd3;
  localparam logic [MODE_W-1:0] MODE_TX_LPF    = 3'd4;
  localparam logic [MODE_W-1:0] MODE_TX_HPF    = 3'd5;

  localparam logic [PINS_W-1:0] PAT_LOW_POWER = 8'h56;
  localparam logic [PINS_W-1:0] PAT_BYPASS    = 8'h66;
  localparam logic [PINS_W-1:0] PAT_RX_LPF    = 8'h9D;
  localparam logic [PINS_W-1:0] PAT_RX_HPF    = 8'h5D;
  localparam logic [PINS_W-1:0] PAT_TX_LPF    = 8'h6B;
  localparam logic [PINS_W-1:0] PAT_TX_HPF    = 8'hAB;

  localparam logic [2:0] PIN_MIXER_EN     = 3'd0;
  localparam logic [2:0] PIN_SHDN_RX_LNA  = 3'd1;
  localparam logic [2:0] PIN_SHDN_TX_LNA  = 3'd2;
  localparam logic [2:0] PIN_TR_VC2       = 3'd3;
  localparam logic [2:0] PIN_TR_VC1_B     = 3'd4;
  localparam logic [2:0] PIN_TR_VC1       = 3'd5;
  localparam logic [2:0] PIN_RX_H_TX_L_B  = 3'd6;
  localparam logic [2:0] PIN_RX_H_TX_L    = 3'd7;

  // Path-switch control bits; everything else is LNA shutdown / mixer enable.
  localparam logic [PINS_W-1:0] SW_FIELD_MASK =
      (PINS_W'(1) << PIN_TR_VC2)   | (PINS_W'(1) << PIN_TR_VC1_B) |
      (PINS_W'(1) << PIN_TR_VC1)   | (PINS_W'(1) << PIN_RX_H_TX_L_B) |
      (PINS_W'(1) << PIN_RX_H_TX_L);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHDN   = 2'd1,
    ST_SWITCH = 2'd2,
    ST_ENABLE = 2'd3
  } state_e;

  function automatic logic mode_is_valid(input logic [MODE_W-1:0] mode);
    return mode <= MODE_TX_HPF;
  endfunction

  function automatic logic [PINS_W-1:0] mode_pattern(input logic [MODE_W-1:0] mode);
    logic [PINS_W-1:0] pat;
    case (mode)
      MODE_LOW_POWER: pat = PAT_LOW_POWER;
      MODE_BYPASS:    pat = PAT_BYPASS;
      MODE_RX_LPF:    pat = PAT_RX_LPF;
      MODE_RX_HPF:    pat = PAT_RX_HPF;
      MODE_TX_LPF:    pat = PAT_TX_LPF;
      MODE_TX_HPF:    pat = PAT_TX_HPF;
      default:        pat = PAT_LOW_POWER;
    endcase
    return pat;
  endfunction

  // Keep the switch bits of src, shut both LNAs down and turn the mixer off.
  function automatic logic [PINS_W-1:0] break_word(input logic [PINS_W-1:0] src);
    logic [PINS_W-1:0] w;
    w                  = src & SW_FIELD_MASK;
    w[PIN_MIXER_EN]    = 1'b0;
    w[PIN_SHDN_RX_LNA] = 1'b1;
    w[PIN_SHDN_TX_LNA] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/rf_switch_seq_if.sv
// Request/status bundle between a controller and the RF switch sequencer.
interface rf_switch_seq_if;
  import rf_pkg::*;

  logic [MODE_W-1:0] i_req_mode;
  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_abort;
  logic              o_busy;
  logic              o_done;
  logic              o_err;
  logic [MODE_W-1:0] o_cur_mode;
  logic [PINS_W-1:0] o_rf_pins;

  modport master (
    output i_req_mode, i_req_valid, i_abort,
    input  o_req_ready, o_busy, o_done, o_err, o_cur_mode, o_rf_pins
  );

  modport slave (
    input  i_req_mode, i_req_valid, i_abort,
    output o_req_ready, o_busy, o_done, o_err, o_cur_mode, o_rf_pins
  );
endinterface

// File: rtl/rf_seq_timer.sv
// Loadable 8-bit down-counter; stops at 1 (never wraps) and flags expiry at 1.
module rf_seq_timer
  import rf_pkg::*;
(
  input  logic             i_sys_clk,
  input  logic             i_reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired_c
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q > CNT_W'(1)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign expired_c = (count_q == CNT_W'(1));

endmodule

// File: rtl/rf_switch_seq.sv
// RF front-end mode sequencer: break LNAs, move path switches, settle, then re-enable.
module rf_switch_seq
  import rf_pkg::*;
#(
  parameter int unsigned P_GUARD_CYC  = 8,
  parameter int unsigned P_SETTLE_CYC = 32
) (
  input  logic           i_sys_clk,
  input  logic           i_reset,
  rf_switch_seq_if.slave bus
);

  state_e            state_q, state_d;
  logic [PINS_W-1:0] pins_q, pins_d;
  logic [MODE_W-1:0] cur_q, cur_d;
  logic [MODE_W-1:0] tgt_q, tgt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;

  logic              accept_c;
  logic              req_ok_c;
  logic              req_same_c;
  logic              tmr_load_c;
  logic [CNT_W-1:0]  tmr_val_c;
  logic              tmr_expired_c;

  assign accept_c   = ready_q & bus.i_req_valid & ~bus.i_abort;
  assign req_ok_c   = mode_is_valid(bus.i_req_mode);
  assign req_same_c = (bus.i_req_mode == cur_q);

  rf_seq_timer u_timer (
    .i_sys_clk (i_sys_clk),
    .i_reset   (i_reset),
    .load      (tmr_load_c),
    .load_val  (tmr_val_c),
    .expired_c (tmr_expired_c)
  );

  // State and registered outputs.
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      pins_q  <= PAT_LOW_POWER;
      cur_q   <= MODE_LOW_POWER;
      tgt_q   <= MODE_LOW_POWER;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pins_q  <= pins_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  // Next state; abort wins over everything, including a simultaneous request.
  always_comb begin
    state_d = state_q;
    if (bus.i_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (accept_c && req_ok_c && !req_same_c) state_d = ST_SHDN;
        ST_SHDN:   if (tmr_expired_c) state_d = ST_SWITCH;
        ST_SWITCH: if (tmr_expired_c) state_d = ST_ENABLE;
        ST_ENABLE: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Output values for the coming cycle, plus counter reload on every state entry.
  always_comb begin
    pins_d     = pins_q;
    cur_d      = cur_q;
    tgt_d      = accept_c ? bus.i_req_mode : tgt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    busy_d     = (state_d != ST_IDLE);
    ready_d    = (state_d == ST_IDLE);
    tmr_load_c = (state_d != state_q) || bus.i_abort;

    case (state_d)
      ST_SHDN:   tmr_val_c = CNT_W'(P_GUARD_CYC);
      ST_SWITCH: tmr_val_c = CNT_W'(P_SETTLE_CYC);
      default:   tmr_val_c = '0;
    endcase

    if (bus.i_abort) begin
      pins_d = PAT_LOW_POWER;
      cur_d  = MODE_LOW_POWER;
    end else begin
      case (state_d)
        ST_SHDN:   pins_d = break_word(pins_q);
        ST_SWITCH: pins_d = break_word(mode_pattern(tgt_q));
        ST_ENABLE: begin
          pins_d = mode_pattern(tgt_q);
          cur_d  = tgt_q;
          done_d = 1'b1;
        end
        default: begin
          if (accept_c) begin
            err_d  = ~req_ok_c;
            done_d = req_ok_c & req_same_c;
          end
        end
      endcase
    end
  end

  assign bus.o_rf_pins   = pins_q;
  assign bus.o_cur_mode  = cur_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_err       = err_q;
  assign bus.o_req_ready = ready_q;

endmodule
